// File: rtl/pe_packet_injector.sv
// pe_packet_injector: packs filter rows and ifmap rows into 64-bit NoC packets addressed to PE1..PE5.
// Optional macro PKT_PARITY_EN puts even parity over the payload field [52:0] into bit 53.
module pe_packet_injector #(
  parameter int         PACKET_WIDTH   = 64,
  parameter int         FILTER_LENGTH  = 40,
  parameter int         IFMAP_LENGTH   = 25,
  parameter int         NUM_IFMAP_ROWS = 25,
  parameter logic [3:0] SRC_ADDR       = 4'b1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     filt_valid,
  output logic                     filt_ready,
  input  logic [FILTER_LENGTH-1:0] filt_data,
  input  logic                     ifmap_valid,
  output logic                     ifmap_ready,
  input  logic [IFMAP_LENGTH-1:0]  ifmap_data,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic [PACKET_WIDTH-1:0]  pkt_data,
  output logic                     busy,
  output logic                     done
);
  localparam int               CNT_W      = $clog2(NUM_IFMAP_ROWS + 1);
  localparam int               BODY_W     = PACKET_WIDTH - 11;
  localparam logic [3:0]       PE1_ADDR   = 4'b0001;
  localparam logic [3:0]       PE2_ADDR   = 4'b0101;
  localparam logic [3:0]       PE3_ADDR   = 4'b0011;
  localparam logic [3:0]       PE4_ADDR   = 4'b0111;
  localparam logic [3:0]       PE5_ADDR   = 4'b1100;
  localparam logic [1:0]       TYPE_IFMAP = 2'b00;
  localparam logic [1:0]       TYPE_FILT  = 2'b01;
  localparam logic [CNT_W-1:0] LAST_FILT  = CNT_W'(4);
  localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(NUM_IFMAP_ROWS - 1);

  typedef enum logic [1:0] {IDLE, FILT, IFMAP, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        filt_cnt_q, filt_cnt_d;
  logic [CNT_W-1:0]        row_cnt_q, row_cnt_d;
  logic                    pkt_valid_q, pkt_valid_d;
  logic [PACKET_WIDTH-1:0] pkt_data_q, pkt_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    free, filt_acc, ifmap_acc;
  logic [BODY_W-1:0]       body;

  // Rows 4 and beyond all enter the chain at PE5; the PEs forward them upward.
  function automatic logic [3:0] pe_addr(input logic [CNT_W-1:0] idx);
    case (idx)
      CNT_W'(0): return PE1_ADDR;
      CNT_W'(1): return PE2_ADDR;
      CNT_W'(2): return PE3_ADDR;
      CNT_W'(3): return PE4_ADDR;
      default:   return PE5_ADDR;
    endcase
  endfunction

  function automatic logic [PACKET_WIDTH-1:0] make_pkt(input logic [3:0]        dest,
                                                       input logic [1:0]        ptype,
                                                       input logic [BODY_W-1:0] pbody);
    logic parity;
`ifdef PKT_PARITY_EN
    parity = ^pbody;
`else
    parity = 1'b0;
`endif
    return {dest, SRC_ADDR, ptype, parity, pbody};
  endfunction

  // The single output slot can take a new row in the same cycle its current packet leaves.
  assign free        = !pkt_valid_q || pkt_ready;
  assign filt_ready  = rst_n && (state_q == FILT) && free;
  assign ifmap_ready = rst_n && (state_q == IFMAP) && free;
  assign filt_acc    = filt_valid && filt_ready;
  assign ifmap_acc   = ifmap_valid && ifmap_ready;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    filt_cnt_d  = filt_cnt_q;
    row_cnt_d   = row_cnt_q;
    pkt_valid_d = pkt_valid_q && !pkt_ready;
    pkt_data_d  = pkt_data_q;
    done_d      = 1'b0;
    body        = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FILT;
          filt_cnt_d = '0;
          row_cnt_d  = '0;
        end
      end
      FILT: begin
        if (filt_acc) begin
          body[FILTER_LENGTH-1:0] = filt_data;
          pkt_data_d  = make_pkt(pe_addr(filt_cnt_q), TYPE_FILT, body);
          pkt_valid_d = 1'b1;
          filt_cnt_d  = filt_cnt_q + CNT_W'(1);
          if (filt_cnt_q == LAST_FILT) state_d = IFMAP;
        end
      end
      IFMAP: begin
        if (ifmap_acc) begin
          body[IFMAP_LENGTH-1:0] = ifmap_data;
          pkt_data_d  = make_pkt(pe_addr(row_cnt_q), TYPE_IFMAP, body);
          pkt_valid_d = 1'b1;
          row_cnt_d   = row_cnt_q + CNT_W'(1);
          if (row_cnt_q == LAST_ROW) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pkt_valid_q && pkt_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      filt_cnt_q  <= '0;
      row_cnt_q   <= '0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_cnt_q  <= filt_cnt_d;
      row_cnt_q   <= row_cnt_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = pkt_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pe_packet_injector.sv
// tb_pe_packet_injector: directed and randomized scenarios checked against a queue-based packet model.
// Build with or without PKT_PARITY_EN; the model follows the same macro.
module tb_pe_packet_injector;
  localparam int N = 7;

  logic        clk = 1'b0;
  logic        rst_n, start, filt_valid, ifmap_valid, pkt_ready;
  logic [39:0] filt_data;
  logic [24:0] ifmap_data;
  logic        filt_ready, ifmap_ready, pkt_valid, busy, done;
  logic [63:0] pkt_data;

  int total = 0;
  int bad   = 0;

  // Model: packets owed to the output in order, plus run progress.
  logic [63:0] exp_q[$];
  bit          m_busy, m_done;
  int          m_filt, m_ifmap;

  pe_packet_injector #(.NUM_IFMAP_ROWS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dest_of(input int k);
    logic [3:0] tab [5];
    tab = '{4'h1, 4'h5, 4'h3, 4'h7, 4'hC};
    return tab[(k > 4) ? 4 : k];
  endfunction

  function automatic logic [63:0] make_pkt(input logic [3:0] dest, input logic [1:0] typ,
                                           input logic [52:0] body);
    logic par;
`ifdef PKT_PARITY_EN
    par = ^body;
`else
    par = 1'b0;
`endif
    return {dest, 4'b1000, typ, par, body};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_busy = 0; m_done = 0; m_filt = 0; m_ifmap = 0;
  endtask

  task automatic idle_inputs();
    start = 0; filt_valid = 0; ifmap_valid = 0; pkt_ready = 0;
    filt_data = '0; ifmap_data = '0;
  endtask

  // Called just after a falling edge with inputs driven; checks this cycle, advances the model, returns at the next falling edge.
  task automatic tick();
    logic [63:0] exp_pkt;
    bit want_v, free_m, exp_fr, exp_ir, go, fin;
    #1;
    want_v = (exp_q.size() != 0);
    total++; if (pkt_valid !== want_v) begin bad++; $display("FAIL pkt_valid: got %b want %b", pkt_valid, want_v); end
    total++; if (busy !== m_busy) begin bad++; $display("FAIL busy: got %b want %b", busy, m_busy); end
    total++; if (done !== m_done) begin bad++; $display("FAIL done: got %b want %b", done, m_done); end
    free_m = !want_v || pkt_ready;
    exp_fr = m_busy && (m_filt < 5) && free_m;
    exp_ir = m_busy && (m_filt == 5) && (m_ifmap < N) && free_m;
    total++; if (filt_ready !== exp_fr) begin bad++; $display("FAIL filt_ready: got %b want %b", filt_ready, exp_fr); end
    total++; if (ifmap_ready !== exp_ir) begin bad++; $display("FAIL ifmap_ready: got %b want %b", ifmap_ready, exp_ir); end
    go  = start && !m_busy;
    fin = 0;
    if (pkt_valid && pkt_ready && exp_q.size() != 0) begin
      exp_pkt = exp_q.pop_front();
      total++; if (pkt_data !== exp_pkt) begin bad++; $display("FAIL pkt_data: got %h want %h", pkt_data, exp_pkt); end
      if (m_filt == 5 && m_ifmap == N && exp_q.size() == 0) fin = 1;
    end
    if (filt_valid && filt_ready) begin
      exp_q.push_back(make_pkt(dest_of(m_filt), 2'b01, 53'(filt_data)));
      m_filt++;
    end
    if (ifmap_valid && ifmap_ready) begin
      exp_q.push_back(make_pkt(dest_of(m_ifmap), 2'b00, 53'(ifmap_data)));
      m_ifmap++;
    end
    m_done = fin;
    if (go) begin m_busy = 1; m_filt = 0; m_ifmap = 0; end
    else if (fin) m_busy = 0;
    @(negedge clk);
  endtask

  // Random traffic until the model expects done in the current cycle; an expired budget is a failure.
  task automatic run_to_done(input int budget);
    int n = 0;
    while (!m_done && n < budget) begin
      start       = ($urandom_range(0, 4) == 0);
      filt_valid  = ($urandom_range(0, 3) != 0);
      filt_data   = {8'($urandom), $urandom};
      ifmap_valid = ($urandom_range(0, 3) != 0);
      ifmap_data  = 25'($urandom);
      pkt_ready   = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    idle_inputs();
    total++; if (!m_done) begin bad++; $display("FAIL run_timeout: got %0d cycles want done within %0d", n, budget); end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 1; filt_valid = 1; ifmap_valid = 1; pkt_ready = 1;
    filt_data = {8'($urandom), $urandom}; ifmap_data = 25'($urandom);
    repeat (4) begin
      @(negedge clk);
      total++;
      if (pkt_valid !== 1'b0 || filt_ready !== 1'b0 || ifmap_ready !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || pkt_data !== 64'h0) begin
        bad++;
        $display("FAIL reset_state: got v=%b fr=%b ir=%b busy=%b done=%b data=%h want all 0",
                 pkt_valid, filt_ready, ifmap_ready, busy, done, pkt_data);
      end
    end
    idle_inputs(); rst_n = 1; model_reset();
    tick();
  endtask

  task automatic test_filter();
    logic [63:0] lits [5];
    logic [63:0] lit;
    lits = '{64'h1840_00A5_0000_0001, 64'h5840_00A5_0000_0002, 64'h3840_00A5_0000_0003,
             64'h7840_00A5_0000_0004, 64'hC840_00A5_0000_0005};
    start = 1; tick(); start = 0;
    pkt_ready = 1;
    for (int k = 0; k < 5; k++) begin
      filt_valid = 1; filt_data = 40'hA5_0000_0000 | 40'(k + 1);
      tick();
      lit = lits[k];
`ifdef PKT_PARITY_EN
      lit[53] = ^lit[52:0];
`endif
      total++;
      if (pkt_valid !== 1'b1 || pkt_data !== lit) begin
        bad++; $display("FAIL filter_pkt%0d: got v=%b %h want %h", k, pkt_valid, pkt_data, lit);
      end
    end
    filt_valid = 0;
  endtask

  task automatic test_ifmap_routing();
    logic [3:0] dests [7];
    logic       want_par;
    int         done_cnt = 0;
    dests = '{4'h1, 4'h5, 4'h3, 4'h7, 4'hC, 4'hC, 4'hC};
`ifdef PKT_PARITY_EN
    want_par = 1'b1;
`else
    want_par = 1'b0;
`endif
    pkt_ready = 1;
    for (int r = 0; r < N; r++) begin
      ifmap_valid = 1; ifmap_data = 25'h1FFFFFF;
      tick();
      total++;
      if (pkt_data[63:56] !== {dests[r], 4'h8} || pkt_data[55:54] !== 2'b00 ||
          pkt_data[53] !== want_par || pkt_data[52:0] !== 53'h1FFFFFF) begin
        bad++; $display("FAIL ifmap_row%0d: got %h want dest %h type 0 body 1ffffff", r, pkt_data, dests[r]);
      end
    end
    ifmap_valid = 0;
    repeat (4) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_run: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    logic [39:0] rows [5];
    for (int k = 0; k < 5; k++) rows[k] = {8'($urandom), $urandom};
    start = 1; tick(); start = 0;
    pkt_ready = 1;
    for (int k = 0; k < 2; k++) begin filt_valid = 1; filt_data = rows[k]; tick(); end
    held = pkt_data;
    pkt_ready = 0; filt_data = rows[2];
    repeat (4) begin
      #1;
      total++; if (filt_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b want 0", filt_ready); end
      tick();
      total++;
      if (pkt_valid !== 1'b1 || pkt_data !== held) begin
        bad++; $display("FAIL stall_hold: got v=%b %h want %h", pkt_valid, pkt_data, held);
      end
    end
    pkt_ready = 1;
    for (int k = 2; k < 5; k++) begin
      filt_data = rows[k]; tick();
      total++;
      if (pkt_valid !== 1'b1 || pkt_data[39:0] !== rows[k]) begin
        bad++; $display("FAIL resume_row%0d: got v=%b %h want %h", k, pkt_valid, pkt_data[39:0], rows[k]);
      end
    end
    filt_valid = 0;
    run_to_done(300);
    tick();
  endtask

  task automatic test_reset_mid_run();
    start = 1; tick(); start = 0;
    pkt_ready = 1;
    repeat (5) begin filt_valid = 1; filt_data = {8'($urandom), $urandom}; tick(); end
    filt_valid = 0;
    repeat (2) begin ifmap_valid = 1; ifmap_data = 25'($urandom); tick(); end
    ifmap_valid = 0; pkt_ready = 0; tick();
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", pkt_valid); end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; model_reset();
    #1;
    total++;
    if (pkt_valid !== 1'b0 || busy !== 1'b0 || filt_ready !== 1'b0 || ifmap_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got v=%b busy=%b fr=%b ir=%b want 0", pkt_valid, busy, filt_ready, ifmap_ready);
    end
    start = 1; tick(); start = 0;
    pkt_ready = 1; filt_valid = 1; filt_data = {8'($urandom), $urandom};
    tick();
    filt_valid = 0;
    total++;
    if (pkt_data[63:54] !== {4'h1, 4'h8, 2'b01}) begin
      bad++; $display("FAIL restart_hdr: got %h want 061", pkt_data[63:54]);
    end
    run_to_done(300);
    tick();
  endtask

  task automatic test_parity();
    start = 1; tick(); start = 0;
    pkt_ready = 1; filt_valid = 1; filt_data = 40'h1;
    tick();
    filt_valid = 0;
`ifdef PKT_PARITY_EN
    total++; if (pkt_data[53] !== 1'b1) begin bad++; $display("FAIL parity_bit: got %b want 1", pkt_data[53]); end
    total++; if ((^pkt_data[53:0]) !== 1'b0) begin bad++; $display("FAIL parity_even: got %b want 0", ^pkt_data[53:0]); end
`else
    total++; if (pkt_data[53] !== 1'b0) begin bad++; $display("FAIL parity_bit: got %b want 0", pkt_data[53]); end
`endif
    run_to_done(300);
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1; tick(); start = 0;
    run_to_done(300);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done); end
    start = 1; tick(); start = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart: got busy=%b want 1", busy); end
    run_to_done(300);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      start = 1; tick(); start = 0;
      run_to_done(400);
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_filter();
    test_ifmap_routing();
    test_backpressure();
    test_reset_mid_run();
    test_parity();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
